// File: rtl/par_ser.sv
// par_ser: transmit-side lane serializer.
// Turns 8-bit parallel words into an MSB-first serial stream, one bit per
// clk_32f cycle. After reset it sends SYNC_COUNT COM characters so the far-end
// receiver can lock. It then accepts user words. A COM idle is sent whenever
// valid_in is low at a word boundary.
//
// Ports:
//   clk_32f   in   bit clock, rising edge
//   reset     in   asynchronous, active-low reset
//   data_in   in   [7:0] parallel word, sampled on a boundary edge
//   valid_in  in   data_in is a real word (else COM is sent)
//   word_req  out  high in the cycle whose ending edge samples data_in/valid_in
//   data_out  out  registered serial bit, MSB first
//   active    out  sync burst finished, user data is being accepted
module par_ser #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4      // legal 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       word_req,
  output logic       data_out,
  output logic       active
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [7:0] word;
  logic       boundary;
  logic       sync_done;

  assign boundary  = (bit_cnt == 3'd0);
  assign sync_done = (com_cnt == SYNC_N);

  // The last SYNC boundary already samples user input, so the request goes
  // out one word before the FSM actually reaches ACTIVE.
  assign word_req = reset && boundary && (state == ACTIVE || sync_done);

  // next-state and word selection; only acts on boundary edges
  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    word        = COM;
    if (boundary) begin
      unique case (state)
        SYNC: begin
          if (!sync_done) begin
            word        = COM;
            com_cnt_nxt = com_cnt + 4'd1;
          end else begin
            // enter ACTIVE and take the first user word on the same edge
            state_nxt = ACTIVE;
            word      = valid_in ? data_in : COM;
          end
        end
        ACTIVE: word = valid_in ? data_in : COM;
        default: ;
      endcase
    end
  end

  // control state
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state   <= SYNC;
      com_cnt <= 4'd0;
      active  <= 1'b0;
    end else begin
      state   <= state_nxt;
      com_cnt <= com_cnt_nxt;
      active  <= (state_nxt == ACTIVE);
    end
  end

  // serializer datapath: bit 7 leaves on the boundary edge, the remaining
  // seven bits drain from the shift register on the following edges
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      data_out <= 1'b0;
    end else if (boundary) begin
      data_out <= word[7];
      shreg    <= word[6:0];
      bit_cnt  <= 3'd1;
    end else begin
      data_out <= shreg[6];
      shreg    <= {shreg[5:0], 1'b0};
      bit_cnt  <= bit_cnt + 3'd1;   // wraps 7 -> 0 onto the next boundary
    end
  end

endmodule

// File: tb/tb_par_ser.sv
module tb_par_ser;
  localparam logic [7:0] COM = 8'hBC;
  localparam int         S   = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       word_req, data_out, active;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  par_ser #(.COM(COM), .SYNC_COUNT(S)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .word_req(word_req),
    .data_out(data_out),
    .active  (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since reset release. Word k starts at edge
  // 8k+1; the first S words are COM, later ones are data_in or COM. Each word
  // is queued as 8 bits MSB first and one bit is popped per edge.
  int   edge_n = 0;
  bit   q[$];
  logic exp_do  = 1'b0;
  logic exp_act = 1'b0;
  logic [7:0] w;

  always @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      edge_n  = 0;
      q.delete();
      exp_do  = 1'b0;
      exp_act = 1'b0;
    end else begin
      edge_n++;
      if ((edge_n - 1) % 8 == 0) begin
        w = (((edge_n - 1) / 8) < S || !valid_in) ? COM : data_in;
        for (int b = 7; b >= 0; b--) q.push_back(w[b]);
      end
      exp_do  = q.pop_front();
      exp_act = (edge_n > 8 * S);
    end
  end

  // per-cycle comparison, away from the active edge
  always @(negedge clk_32f) begin
    if (cmp_en) begin
      chk("data_out", {7'd0, data_out}, {7'd0, exp_do});
      chk("active",   {7'd0, active},   {7'd0, exp_act});
      chk("word_req", {7'd0, word_req},
          {7'd0, reset && (edge_n % 8 == 0) && (edge_n >= 8 * S)});
    end
  end

  task automatic get_byte(output logic [7:0] b);
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_32f); #1;
      b = {b[6:0], data_out};
    end
  endtask

  // Present one word in the word_req cycle, then scramble the inputs for the
  // rest of the word: they only matter on the sampling edge.
  task automatic send_word(input logic [7:0] d, input logic v);
    data_in  = d;
    valid_in = v;
    @(posedge clk_32f); #1;
    data_in  = 8'($urandom);
    valid_in = 1'($urandom);
    repeat (7) begin @(posedge clk_32f); #1; end
  endtask

  logic [7:0] b;

  initial begin
    reset    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    #1 cmp_en = 1'b1;

    // reset held with the clock running
    repeat (4) @(posedge clk_32f);
    #1;
    chk("rst_data_out", {7'd0, data_out}, 8'd0);
    chk("rst_active",   {7'd0, active},   8'd0);
    chk("rst_word_req", {7'd0, word_req}, 8'd0);

    // sync burst: valid data must be ignored
    reset    = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h00;
    for (int k = 0; k < S; k++) begin
      get_byte(b);
      chk("sync_word", b, 8'hBC);
    end
    chk("req_before_33", {7'd0, word_req}, 8'd1);
    chk("act_before_33", {7'd0, active},   8'd0);

    // first data words, back to back
    data_in = 8'hA5; valid_in = 1'b1;
    @(posedge clk_32f); #1;
    chk("act_at_33", {7'd0, active}, 8'd1);
    b = {7'd0, data_out};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_32f); #1;
      b = {b[6:0], data_out};
    end
    chk("word_A5", b, 8'hA5);
    data_in = 8'h3C; valid_in = 1'b1;
    get_byte(b);
    chk("word_3C", b, 8'h3C);
    data_in = 8'hFF; valid_in = 1'b0;
    get_byte(b);
    chk("idle_fill", b, 8'hBC);
    data_in = COM; valid_in = 1'b1;
    get_byte(b);
    chk("com_as_data", b, 8'hBC);

    // randomized traffic, checked by the model
    repeat (40) send_word(8'($urandom), 1'($urandom));

    // reset mid-word truncates and restarts the burst
    data_in = 8'hA5; valid_in = 1'b1;
    repeat (4) @(posedge clk_32f);
    #1 reset = 1'b0;
    #1;
    chk("midrst_data_out", {7'd0, data_out}, 8'd0);
    chk("midrst_active",   {7'd0, active},   8'd0);
    chk("midrst_word_req", {7'd0, word_req}, 8'd0);
    repeat (2) @(posedge clk_32f);
    #1 reset = 1'b1;
    data_in = 8'h77; valid_in = 1'b1;
    for (int k = 0; k < S; k++) begin
      get_byte(b);
      chk("resync_word", b, 8'hBC);
      chk("resync_active", {7'd0, active}, 8'd0);
    end
    repeat (20) send_word(8'($urandom), 1'($urandom));

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop so the run cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
